// File: rtl/ifu_imem.sv
// Instruction memory slave with an AXI-lite-style read channel and a preload write port.
// Response arrives D+1 cycles after the AR handshake; it is held until ifu_rready, and AR is refused meanwhile.
module ifu_imem #(
    parameter int          DEPTH_LOG2  = 12,
    parameter logic [31:0] BASE        = 32'h8000_0000,
    parameter int          RAND_DELAY  = 0,
    parameter int          FIXED_DELAY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic        ifu_rready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);
    localparam int          WORDS = 1 << DEPTH_LOG2;
    localparam logic [32:0] SIZE  = 33'd4 << DEPTH_LOG2;
    localparam logic [4:0]  FIX_D = 5'(FIXED_DELAY);

    typedef enum logic [1:0] {IDLE, DELAY, RESP} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [31:0] addr_q;
    logic [15:0] lfsr;
    logic [4:0]  dly;
    logic        ar_hs, enter_resp;
    logic [31:0] rd_addr, rd_data;
    logic [1:0]  rd_resp;
    logic [DEPTH_LOG2-1:0] rd_idx, ld_idx;
    logic        ld_ok, ld_hit;
    logic [31:0] mem [0:WORDS-1];

    // Range test done on the offset so an address below BASE can never alias into the window.
    function automatic logic in_win(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a >= BASE) && ({1'b0, off} < SIZE);
    endfunction

    assign ifu_arready = (state == IDLE) && !rst;
    assign ar_hs       = ifu_arready && ifu_arvalid;
    assign dly         = (RAND_DELAY != 0) ? lfsr[4:0] : FIX_D;

    // With zero delay RESP is entered on the handshake edge itself, before addr_q is loaded.
    assign rd_addr = (state == IDLE) ? ifu_araddr : addr_q;
    assign rd_idx  = DEPTH_LOG2'((rd_addr - BASE) >> 2);
    assign ld_idx  = DEPTH_LOG2'((ld_addr - BASE) >> 2);
    assign ld_ok   = ld_en && (ld_addr[1:0] == 2'b00) && in_win(ld_addr);
    assign ld_hit  = ld_ok && (ld_idx == rd_idx);

    always_comb begin
        rd_resp = 2'b00;
        rd_data = 32'd0;
        if (rd_addr[1:0] != 2'b00) begin
            rd_resp = 2'b10;
        end else if (!in_win(rd_addr)) begin
            rd_resp = 2'b11;
        end else begin
            rd_data = ld_hit ? ld_data : mem[rd_idx];
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    if (dly == 5'd0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = DELAY;
                        cnt_nxt   = dly - 5'd1;
                    end
                end
            end
            DELAY: begin
                if (cnt == 5'd0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 5'd1;
                end
            end
            RESP: begin
                if (ifu_rready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            addr_q     <= 32'd0;
            lfsr       <= 16'hACE1;
            ifu_rvalid <= 1'b0;
            ifu_rdata  <= 32'd0;
            ifu_rresp  <= 2'b00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lfsr  <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if (ar_hs) begin
                addr_q <= ifu_araddr;
            end
            if (enter_resp) begin
                ifu_rvalid <= 1'b1;
                ifu_rdata  <= rd_data;
                ifu_rresp  <= rd_resp;
            end else if ((state == RESP) && ifu_rready) begin
                ifu_rvalid <= 1'b0;
            end
        end
    end

    // Preload port is independent of reset and FSM state.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_idx] <= ld_data;
        end
    end
endmodule

// File: tb/tb_ifu_imem.sv
module tb_ifu_imem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = 32'd0;
    logic [3:0]  arvalid = 4'd0;
    logic        rready = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = 32'd0;
    logic [31:0] ld_data = 32'd0;
    logic        arready [4];
    logic [31:0] rdata [4];
    logic [1:0]  rresp [4];
    logic        rvalid [4];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    // Reference LFSR: Fibonacci, taps 16,14,13,11, free-running out of reset.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    ifu_imem #(.FIXED_DELAY(0)) u_d0 (.clk(clk), .rst(rst), .ifu_araddr(araddr), .ifu_arvalid(arvalid[0]),
        .ifu_arready(arready[0]), .ifu_rready(rready), .ifu_rdata(rdata[0]), .ifu_rresp(rresp[0]),
        .ifu_rvalid(rvalid[0]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
    ifu_imem #(.FIXED_DELAY(5)) u_d5 (.clk(clk), .rst(rst), .ifu_araddr(araddr), .ifu_arvalid(arvalid[1]),
        .ifu_arready(arready[1]), .ifu_rready(rready), .ifu_rdata(rdata[1]), .ifu_rresp(rresp[1]),
        .ifu_rvalid(rvalid[1]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
    ifu_imem #(.FIXED_DELAY(4)) u_d4 (.clk(clk), .rst(rst), .ifu_araddr(araddr), .ifu_arvalid(arvalid[2]),
        .ifu_arready(arready[2]), .ifu_rready(rready), .ifu_rdata(rdata[2]), .ifu_rresp(rresp[2]),
        .ifu_rvalid(rvalid[2]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
    ifu_imem #(.RAND_DELAY(1)) u_rnd (.clk(clk), .rst(rst), .ifu_araddr(araddr), .ifu_arvalid(arvalid[3]),
        .ifu_arready(arready[3]), .ifu_rready(rready), .ifu_rdata(rdata[3]), .ifu_rresp(rresp[3]),
        .ifu_rvalid(rvalid[3]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Stimulus only: one read with rready held high; returns what was observed.
    task automatic do_read(input int k, input logic [31:0] a, output int lat, output logic [31:0] d,
                           output logic [1:0] r, output logic [4:0] lfsr_d, output logic post_vld);
        int w = 0;
        while (!arready[k] && w < 64) begin tick(); w++; end
        araddr = a; arvalid[k] = 1'b1; rready = 1'b1; lfsr_d = m_lfsr[4:0];
        tick();
        arvalid[k] = 1'b0;
        lat = 1;
        while (!rvalid[k] && lat < 64) begin tick(); lat++; end
        d = rdata[k]; r = rresp[k];
        tick();
        post_vld = rvalid[k];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({arready[k], rvalid[k], rdata[k], rresp[k]} !== 36'd0) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d: got rdy=%b vld=%b dat=%h resp=%b want all 0",
                         k, arready[k], rvalid[k], rdata[k], rresp[k]);
            end
        end
        // Preload while still in reset: memory must not care.
        load(32'h8000_0000, 32'h0000_0413);
        load(32'h8000_0004, 32'h2222_2222);
        load(32'h8000_0005, 32'hBAD0_BAD0);
        load(32'h8000_0008, 32'h3333_3333);
        load(32'h8000_0010, 32'h1111_1111);
        load(32'h8000_0014, 32'h5555_5555);
        load(32'h8000_3FFC, 32'hCAFE_F00D);
        load(32'h8000_4000, 32'hBAD1_BAD1);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (arready[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_release_arready dut%0d: got %b want 1", k, arready[k]);
            end
        end
    endtask

    task automatic test_basic();
        int lat; logic [31:0] d; logic [1:0] r; logic [4:0] ld; logic pv;
        logic [31:0] addrs [3] = '{32'h8000_0000, 32'h8000_3FFC, 32'h8000_0004};
        logic [31:0] exps  [3] = '{32'h0000_0413, 32'hCAFE_F00D, 32'h2222_2222};
        for (int i = 0; i < 3; i++) begin
            do_read(0, addrs[i], lat, d, r, ld, pv);
            n_cmp++;
            if (lat !== 1 || d !== exps[i] || r !== 2'b00) begin
                n_bad++;
                $display("FAIL basic_read %h: got lat=%0d dat=%h resp=%b want lat=1 dat=%h resp=00",
                         addrs[i], lat, d, r, exps[i]);
            end
            n_cmp++;
            if (pv !== 1'b0 || arready[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL basic_idle_after %h: got vld=%b rdy=%b want vld=0 rdy=1", addrs[i], pv, arready[0]);
            end
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] d; logic [1:0] r; logic [4:0] ld; logic pv;
        logic [31:0] addrs [4] = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_4000, 32'h8000_4001};
        logic [1:0]  exps  [4] = '{2'b10, 2'b11, 2'b11, 2'b10};
        for (int i = 0; i < 4; i++) begin
            do_read(0, addrs[i], lat, d, r, ld, pv);
            n_cmp++;
            if (lat !== 1 || d !== 32'd0 || r !== exps[i]) begin
                n_bad++;
                $display("FAIL error_resp %h: got lat=%0d dat=%h resp=%b want lat=1 dat=0 resp=%b",
                         addrs[i], lat, d, r, exps[i]);
            end
        end
    endtask

    task automatic test_stall();
        int lat; logic rdy_seen = 1'b0; logic bad_hold = 1'b0;
        araddr = 32'h8000_0008; rready = 1'b0; arvalid[1] = 1'b1;
        tick();
        araddr = 32'h8000_0000;  // stray request held high while busy must be ignored
        lat = 1;
        while (!rvalid[1] && lat < 64) begin
            if (arready[1]) rdy_seen = 1'b1;
            tick(); lat++;
        end
        n_cmp++;
        if (lat !== 6) begin
            n_bad++;
            $display("FAIL stall_latency: got %0d want 6", lat);
        end
        for (int c = 0; c < 3; c++) begin
            if (rvalid[1] !== 1'b1 || rdata[1] !== 32'h3333_3333 || rresp[1] !== 2'b00) bad_hold = 1'b1;
            if (arready[1]) rdy_seen = 1'b1;
            if (c < 2) tick();
        end
        n_cmp++;
        if (bad_hold) begin
            n_bad++;
            $display("FAIL stall_hold: got vld=%b dat=%h want vld=1 dat=33333333 stable", rvalid[1], rdata[1]);
        end
        n_cmp++;
        if (rdy_seen) begin
            n_bad++;
            $display("FAIL stall_arready: got 1 while busy want 0");
        end
        rready = 1'b1; arvalid[1] = 1'b0;
        tick();
        n_cmp++;
        if (rvalid[1] !== 1'b0 || arready[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release: got vld=%b rdy=%b want vld=0 rdy=1", rvalid[1], arready[1]);
        end
        bad_hold = 1'b0;
        repeat (8) begin tick(); if (rvalid[1] !== 1'b0) bad_hold = 1'b1; end
        n_cmp++;
        if (bad_hold) begin
            n_bad++;
            $display("FAIL stall_no_second_txn: got vld=1 want 0");
        end
    endtask

    task automatic test_write_first();
        int lat;
        // Load to the pending word two cycles after the handshake.
        araddr = 32'h8000_0010; rready = 1'b1; arvalid[2] = 1'b1;
        tick(); arvalid[2] = 1'b0; lat = 1;
        tick(); lat++;
        load(32'h8000_0010, 32'hDEAD_BEEF); lat++;
        while (!rvalid[2] && lat < 64) begin tick(); lat++; end
        n_cmp++;
        if (lat !== 5 || rdata[2] !== 32'hDEAD_BEEF || rresp[2] !== 2'b00) begin
            n_bad++;
            $display("FAIL write_first_early: got lat=%0d dat=%h want lat=5 dat=deadbeef", lat, rdata[2]);
        end
        tick();
        // Load on the very edge that enters RESP.
        araddr = 32'h8000_0014; arvalid[2] = 1'b1;
        tick(); arvalid[2] = 1'b0; lat = 1;
        repeat (3) begin tick(); lat++; end
        load(32'h8000_0014, 32'hFEED_C0DE); lat++;
        n_cmp++;
        if (lat !== 5 || rvalid[2] !== 1'b1 || rdata[2] !== 32'hFEED_C0DE) begin
            n_bad++;
            $display("FAIL write_first_edge: got lat=%0d vld=%b dat=%h want lat=5 vld=1 dat=feedc0de",
                     lat, rvalid[2], rdata[2]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] d; logic [1:0] r; logic [4:0] ld; logic pv; logic stale = 1'b0;
        araddr = 32'h8000_0000; rready = 1'b1; arvalid[1] = 1'b1;
        tick(); arvalid[1] = 1'b0;
        tick();
        rst = 1'b1;
        repeat (2) begin tick(); if (rvalid[1] !== 1'b0) stale = 1'b1; end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (arready[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_arready: got %b want 1", arready[1]);
        end
        repeat (8) begin tick(); if (rvalid[1] !== 1'b0) stale = 1'b1; end
        n_cmp++;
        if (stale) begin
            n_bad++;
            $display("FAIL reset_mid_stale_rvalid: got 1 want 0");
        end
        do_read(1, 32'h8000_0000, lat, d, r, ld, pv);
        n_cmp++;
        if (lat !== 6 || d !== 32'h0000_0413 || r !== 2'b00 || pv !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_recover: got lat=%0d dat=%h resp=%b want lat=6 dat=00000413 resp=00", lat, d, r);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] d; logic [1:0] r; logic [4:0] ld; logic pv;
        logic [31:0] m [8];
        logic [31:0] a, ed; logic [1:0] er;
        for (int i = 0; i < 8; i++) begin
            m[i] = 32'hA5A5_A5A5 ^ (32'h0101_0101 * i);
            load(32'h8000_0100 + 32'(4 * i), m[i]);
        end
        for (int i = 0; i < 1000; i++) begin
            a = 32'h8000_0100 + 32'(4 * (i % 8)); ed = m[i % 8]; er = 2'b00;
            if (i % 7 == 3)       begin a = a + 32'd2;            ed = 32'd0; er = 2'b10; end
            else if (i % 11 == 5) begin a = 32'h8000_4000 + a[7:0]; ed = 32'd0; er = 2'b11; end
            do_read(3, a, lat, d, r, ld, pv);
            n_cmp++;
            if (lat !== int'(ld) + 1) begin
                n_bad++;
                $display("FAIL rand_latency #%0d: got %0d want %0d", i, lat, int'(ld) + 1);
            end
            n_cmp++;
            if (d !== ed || r !== er) begin
                n_bad++;
                $display("FAIL rand_data #%0d %h: got dat=%h resp=%b want dat=%h resp=%b", i, a, d, r, ed, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_stall();
        test_write_first();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ifu_imem.md
IFU_IMEM -- requirements
Module: ifu_imem

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the number of 32-bit words stored.
REQ-002 SHALL have parameter BASE, default 32'h80000000, meaning the byte address of word 0.
REQ-003 SHALL have parameter RAND_DELAY, default 0, meaning 0 selects a fixed delay and 1 selects an LFSR-derived delay.
REQ-004 SHALL have parameter FIXED_DELAY, default 0, meaning the extra wait cycles (0-31) used when RAND_DELAY=0.
REQ-005 SHALL have ports: clk input 1, the single clock; all logic is on the rising edge.
REQ-006 SHALL have ports: rst input 1, the synchronous active-high reset.
REQ-007 SHALL have ports: ifu_araddr input 32, the read byte address.
REQ-008 SHALL have ports: ifu_arvalid input 1, ifu_arready output 1, ifu_rready input 1, as the AR and R handshake signals.
REQ-009 SHALL have ports: ifu_rdata output 32, ifu_rresp output 2, ifu_rvalid output 1, as the read response.
REQ-010 SHALL have ports: ld_en input 1, ld_addr input 32, ld_data input 32, as the preload write port (byte address).

Function
REQ-011 SHALL implement a three-state FSM: IDLE, DELAY, RESP.
REQ-012 SHALL drive ifu_arready=1 only in IDLE; an AR handshake occurs on a cycle where ifu_arvalid and ifu_arready are both 1.
REQ-013 SHALL, on an AR handshake, latch ifu_araddr and a delay value D (0-31).
- D=0: next state is RESP.
- D>0: next state is DELAY, with the counter loaded to D-1.
REQ-014 SHALL, in DELAY, decrement the counter each cycle and enter RESP on the edge where the counter equals 0.
- Net effect: the first cycle with ifu_rvalid=1 is exactly D+1 cycles after the handshake cycle.
REQ-015 SHALL register ifu_rdata and ifu_rresp on the edge that enters RESP, and hold them stable while ifu_rvalid=1.
REQ-016 SHALL hold ifu_rvalid=1 in RESP until ifu_rready=1; on an R handshake, the next state is IDLE and ifu_rvalid falls.
REQ-017 SHALL accept ifu_rready asserted before ifu_rvalid; ifu_rvalid SHALL NOT depend combinationally on ifu_rready.
REQ-018 SHALL decode ifu_rresp as follows; ifu_rdata SHALL be 0 whenever ifu_rresp is not 2'b00.
- 2'b00 OKAY: address is word-aligned and within [BASE, BASE + 4*2^DEPTH_LOG2).
- 2'b10 SLVERR: address is misaligned (addr[1:0] != 0).
- 2'b11 DECERR: address is aligned but out of range; wrap-around SHALL NOT occur.
- Misalignment SHALL take priority over range.
REQ-019 SHALL compute the word index as (addr - BASE) >> 2, using 32-bit unsigned arithmetic.
REQ-020 SHALL write ld_data to the word at ld_addr when ld_en=1, in any state; out-of-range or misaligned loads SHALL be ignored.
REQ-021 SHALL return the newly loaded data when a load hits the same word as a pending read on or before the edge entering RESP (write-first).
REQ-022 SHALL, when RAND_DELAY=1, use a 16-bit Fibonacci LFSR with taps 16,14,13,11 that advances every cycle; D = lfsr[4:0] sampled at the handshake.
REQ-023 SHALL, when RAND_DELAY=0, use D = FIXED_DELAY[4:0].
REQ-024 SHALL ignore ifu_arvalid outside IDLE; only one transaction SHALL be outstanding at a time.

Reset
REQ-025 SHALL, while rst=1, set state=IDLE, counter=0, ifu_rvalid=0, ifu_rdata=0, ifu_rresp=0, LFSR=16'hACE1, and ifu_arready=0.
- ifu_arready SHALL become 1 in the first cycle after rst falls.
REQ-026 SHALL abort any transaction in DELAY or RESP when rst is asserted mid-operation; no stale ifu_rvalid SHALL follow reset.
REQ-027 SHALL leave memory contents unaffected by rst.

Verification
REQ-028 Preload word 0x80000000 = 0x00000413; with FIXED_DELAY=0, handshake at cycle N with ifu_rready=1 -> ifu_rvalid=1 at N+1, ifu_rdata=0x00000413, ifu_rresp=00, back in IDLE at N+2.
REQ-029 With FIXED_DELAY=5, ifu_rready held 0 for 3 cycles after ifu_rvalid rises -> ifu_rvalid rises at N+6, data stays stable through the stall, and ifu_arready=0 throughout.
REQ-030 Read 0x80000002 -> ifu_rresp=10, ifu_rdata=0; read 0x7FFFFFFC and 0x80004000 (DEPTH_LOG2=12) -> ifu_rresp=11, ifu_rdata=0.
REQ-031 With FIXED_DELAY=4, handshake to 0x80000010 and a load of 0xDEADBEEF to the same word 2 cycles later -> ifu_rdata=0xDEADBEEF.
REQ-032 Assert rst during DELAY -> ifu_rvalid stays 0, ifu_arready=1 the cycle after rst falls, and a new read completes normally.
REQ-033 With RAND_DELAY=1, 1000 back-to-back reads -> every latency equals lfsr[4:0]+1 per a reference model, and data always matches the model.
